memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Shares one single-ported synchronous RAM between the core's instruction-fetch port and its data (load/store) port. It sits between `core` and the unified memory. It serialises the two requesters with a small ownership state machine. Completion is signalled to each requester by a one-cycle ready pulse, and read data is held stable until that port's next read completes.

## Interface
- `ADDRESS_WIDTH`, 32, width of all address buses (byte addresses)
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `fetch_request`  in  1  fetch access requested; held high until `fetch_ready`
- `fetch_address`  in  ADDRESS_WIDTH  fetch byte address; stable while `fetch_request` is high
- `fetch_ready`  out  1  one-cycle completion pulse for fetch
- `fetch_value`  out  32  fetched word
- `data_request`  in  1  data access requested; held high until `data_ready`
- `data_address`  in  ADDRESS_WIDTH  data byte address
- `data_write_sections`  in  3  write-lane mask in core encoding: bit2 high half-word, bit1 low-half high byte, bit0 low byte; 0 = read
- `data_write_value`  in  32  store data
- `data_ready`  out  1  one-cycle completion pulse for data
- `data_read_value`  out  32  loaded word
- `ram_enable`  out  1  access issued to RAM this cycle
- `ram_address`  out  ADDRESS_WIDTH  RAM address
- `ram_write_sections`  out  3  RAM write-lane mask; 0 = read
- `ram_write_value`  out  32  RAM write data
- `ram_read_value`  in  32  RAM read data, valid the cycle after a read issue

## Operation
- States: IDLE and ACCESS. A 1-bit `owner` register (FETCH/DATA) records which port has an access in flight.
- **IDLE:**
  - If `data_request` is high, issue the data access and go to ACCESS with owner = DATA. Data has priority in IDLE.
  - Otherwise, if `fetch_request` is high, issue the fetch (`ram_write_sections` = 0) and go to ACCESS with owner = FETCH.
  - Otherwise stay in IDLE.
- **Issue:** drive `ram_enable`=1 and `ram_address` from the granted port. Drive `ram_write_sections`/`ram_write_value` from the data port when granted; otherwise they are 0.
- **ACCESS:**
  - Pulse the owner's ready signal.
  - If the owner is reading, its `*_value` output equals `ram_read_value` combinationally, and the same value is captured into that port's hold register.
  - In the same cycle, if the *other* port is requesting, issue it, flip `owner`, and stay in ACCESS. Otherwise return to IDLE.
  - The owner's own request line is ignored during its ready cycle; it is only re-evaluated from the next cycle.
- **Hold registers:**
  - `fetch_value` and `data_read_value` show their hold register whenever not in that port's read-ready cycle.
  - Writes never change `data_read_value`.
- **Idle drive:** when nothing is issued, `ram_enable`, `ram_write_sections`, `ram_address` and `ram_write_value` are all 0.
- **Write acknowledge:** a write completes (its ready pulse) the cycle after issue. RAM contents are updated at the end of the issue cycle, so any later read sees the new data.
- **Reset:** while `reset` is high, all RAM outputs are forced to 0 (no write can occur). Next state is IDLE, owner = FETCH, hold registers = 0, and any in-flight access is discarded with no ready pulse.

## Timing
- Latency: an access issued in cycle N from IDLE has its ready pulse in N+1.
- A request arriving while the other port is in flight is issued in that port's ready cycle and completes one cycle later. Worst-case wait from request to ready is 2 cycles.
- Throughput: under continuous contention, one completion per cycle, with grants alternating D, F, D, F…
- Ready pulses are exactly one cycle wide and never asserted for both ports in the same cycle.
- Reset values: `fetch_ready`=0, `data_ready`=0, `ram_enable`=0, `ram_write_sections`=0, `ram_address`=0, `ram_write_value`=0, `fetch_value`=0, `data_read_value`=0.
- After deassertion, the first issue can occur in the first cycle with `reset` low.

## Test plan
- **Reset:** hold `reset` for 2 cycles with both requests high. Required: every output is 0 throughout; first grant (data) in the cycle `reset` falls.
- **Single fetch:** `fetch_address`=0x100, RAM word 0x00500093. Required: `ram_enable` in N, `fetch_ready` only in N+1, `fetch_value`=0x00500093 in N+1 and held through N+5.
- **Simultaneous requests at N:** required sequence is data issued N, `data_ready` plus fetch issue in N+1, `fetch_ready` in N+2, IDLE in N+3.
- **Store then fetch:**
  - SW 0xDEADBEEF to 0x200 (sections 111), then fetch 0x200. Required: `fetch_value`=0xDEADBEEF.
  - SB 0x12 (sections 001) to 0x200, then load. Required: 0xDEADBE12; `data_read_value` unchanged across the store acks.
- **Contention:** both requests high for 10 cycles, with distinct addresses per transaction. Required: alternating ready pulses every cycle and no port waiting more than 2 cycles.
- **Reset mid-operation:** assert `reset` in the issue cycle of an SW 0xCAFEF00D to 0x300. Required: `ram_write_sections`=0 in that cycle, no ready pulse afterwards, and a subsequent read of 0x300 returns the old contents.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises instruction-fetch and data ports onto one synchronous RAM
module memory_arbiter #(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_request,
  input  logic [ADDRESS_WIDTH-1:0] fetch_address,
  output logic                     fetch_ready,
  output logic [31:0]              fetch_value,
  input  logic                     data_request,
  input  logic [ADDRESS_WIDTH-1:0] data_address,
  input  logic [2:0]               data_write_sections,
  input  logic [31:0]              data_write_value,
  output logic                     data_ready,
  output logic [31:0]              data_read_value,
  output logic                     ram_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [2:0]               ram_write_sections,
  output logic [31:0]              ram_write_value,
  input  logic [31:0]              ram_read_value
);
  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {FETCH, DATA} owner_t;
  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  logic data_write_q, data_write_d;
  logic [31:0] fetch_hold_q, fetch_hold_d, data_hold_q, data_hold_d;
  logic grant_fetch, grant_data, data_read_ready;
  // grants (data wins from IDLE, the non-owner is served during the owner's ready cycle), RAM drive and port outputs
  always_comb begin
    fetch_ready = !reset && state_q == ACCESS && owner_q == FETCH;
    data_ready = !reset && state_q == ACCESS && owner_q == DATA;
    data_read_ready = data_ready && !data_write_q;
    grant_data = !reset && data_request && (state_q == IDLE || owner_q == FETCH);
    grant_fetch = !reset && fetch_request && (state_q == IDLE ? !data_request : owner_q == DATA);
    ram_enable = grant_data || grant_fetch;
    ram_address = grant_data ? data_address : grant_fetch ? fetch_address : '0;
    ram_write_sections = grant_data ? data_write_sections : 3'b0;
    ram_write_value = grant_data ? data_write_value : 32'b0;
    fetch_value = reset ? 32'b0 : fetch_ready ? ram_read_value : fetch_hold_q;
    data_read_value = reset ? 32'b0 : data_read_ready ? ram_read_value : data_hold_q;
    state_d = ram_enable ? ACCESS : IDLE;
    owner_d = grant_data ? DATA : grant_fetch ? FETCH : owner_q;
    data_write_d = grant_data ? |data_write_sections : data_write_q;
    fetch_hold_d = fetch_value;
    data_hold_d = data_read_value;
  end
  // state, owner and hold registers; reset drops any in-flight access
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= FETCH;
      data_write_q <= 1'b0;
      fetch_hold_q <= '0;
      data_hold_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      data_write_q <= data_write_d;
      fetch_hold_q <= fetch_hold_d;
      data_hold_q <= data_hold_d;
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed and randomized checks of memory_arbiter against a transaction-level model
module tb_memory_arbiter;
  logic clk = 0, reset = 1;
  logic fetch_request = 0, data_request = 0;
  logic [31:0] fetch_address = 0, data_address = 0, data_write_value = 0;
  logic [2:0] data_write_sections = 0;
  logic fetch_ready, data_ready, ram_enable;
  logic [31:0] fetch_value, data_read_value, ram_address, ram_write_value;
  logic [2:0] ram_write_sections;
  logic [31:0] ram_read_value = 0;
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  int nvec = 0, nerr = 0;
  logic m_busy = 0, m_data = 0, m_read = 0;
  logic [31:0] m_val = 0, m_fh = 0, m_dh = 0;
  int fw = 0, dw = 0;
  logic f_seen = 0, d_seen = 0;

  memory_arbiter #(.ADDRESS_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .fetch_request(fetch_request), .fetch_address(fetch_address),
    .fetch_ready(fetch_ready), .fetch_value(fetch_value),
    .data_request(data_request), .data_address(data_address),
    .data_write_sections(data_write_sections), .data_write_value(data_write_value),
    .data_ready(data_ready), .data_read_value(data_read_value),
    .ram_enable(ram_enable), .ram_address(ram_address),
    .ram_write_sections(ram_write_sections), .ram_write_value(ram_write_value),
    .ram_read_value(ram_read_value)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nv, input logic [2:0] s);
    return {s[2] ? nv[31:16] : old[31:16], s[1] ? nv[15:8] : old[15:8], s[0] ? nv[7:0] : old[7:0]};
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return i == 'h40 ? 32'h00500093 : i == 'h41 ? 32'h11112222 : i == 'h42 ? 32'h22223333 :
           i == 'hC0 ? 32'h0BADF00D : 32'(i) * 32'h9E3779B1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic new_data;
    data_address = $urandom & 32'hFFF;
    data_write_sections = ($urandom_range(0, 1) == 0) ? 3'b0 : 3'($urandom_range(1, 7));
    data_write_value = $urandom;
  endtask

  task automatic new_fetch;
    fetch_address = $urandom & 32'hFFF;
  endtask

  // single-ported synchronous RAM: writes land at the issue edge, read data appears the next cycle
  initial begin : ram_model
    for (int i = 0; i < 256; i++) ram[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (ram_enable && ram_write_sections != 3'b0)
        ram[ram_address[9:2]] <= merge(ram[ram_address[9:2]], ram_write_value, ram_write_sections);
      ram_read_value <= (ram_enable && ram_write_sections == 3'b0) ? ram[ram_address[9:2]] : $urandom;
    end
  end

  // transaction-level reference: one access in flight, completed the cycle after issue
  initial begin : model
    logic rf, rd, gf, gd;
    logic [7:0] ix;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      f_seen = fetch_ready;
      d_seen = data_ready;
      if (reset) begin
        chk("rst_ready", {30'b0, fetch_ready, data_ready}, 32'h0);
        chk("rst_ram_en", {31'b0, ram_enable}, 32'h0);
        chk("rst_ram_addr", ram_address, 32'h0);
        chk("rst_ram_sec", {29'b0, ram_write_sections}, 32'h0);
        chk("rst_ram_wv", ram_write_value, 32'h0);
        chk("rst_fetch_value", fetch_value, 32'h0);
        chk("rst_data_value", data_read_value, 32'h0);
        m_busy = 0;
        m_fh = 0;
        m_dh = 0;
        fw = 0;
        dw = 0;
      end else begin
        rf = m_busy && !m_data;
        rd = m_busy && m_data;
        gd = data_request && !rd;
        gf = fetch_request && (m_busy ? m_data : !data_request);
        chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, rf});
        chk("data_ready", {31'b0, data_ready}, {31'b0, rd});
        chk("ram_en", {31'b0, ram_enable}, {31'b0, gd || gf});
        chk("ram_addr", ram_address, gd ? data_address : gf ? fetch_address : 32'h0);
        chk("ram_sec", {29'b0, ram_write_sections}, {29'b0, gd ? data_write_sections : 3'b0});
        chk("ram_wv", ram_write_value, gd ? data_write_value : 32'h0);
        chk("fetch_value", fetch_value, rf ? m_val : m_fh);
        chk("data_value", data_read_value, rd && m_read ? m_val : m_dh);
        if (fetch_ready) begin
          chk("fetch_wait", 32'(fw <= 2), 32'h1);
          fw = 0;
        end else if (fetch_request) fw++;
        if (data_ready) begin
          chk("data_wait", 32'(dw <= 2), 32'h1);
          dw = 0;
        end else if (data_request) dw++;
        if (fw > 2) begin
          chk("fetch_wait_bound", fw, 32'h2);
          fw = 0;
        end
        if (dw > 2) begin
          chk("data_wait_bound", dw, 32'h2);
          dw = 0;
        end
        if (rf) m_fh = m_val;
        if (rd && m_read) m_dh = m_val;
        m_busy = gd || gf;
        m_data = gd;
        if (gd) begin
          ix = data_address[9:2];
          m_read = data_write_sections == 3'b0;
          m_val = ref_mem[ix];
          if (!m_read) ref_mem[ix] = merge(ref_mem[ix], data_write_value, data_write_sections);
        end else if (gf) begin
          m_read = 1;
          m_val = ref_mem[fetch_address[9:2]];
        end
      end
    end
  end

  initial begin : stimulus
    fetch_request = 1;
    fetch_address = 32'h108;
    data_request = 1;
    data_address = 32'h104;
    data_write_sections = 3'b0;
    repeat (2) begin
      smp;
      chk("lit_rst_en", {31'b0, ram_enable}, 32'h0);
      chk("lit_rst_rdy", {30'b0, fetch_ready, data_ready}, 32'h0);
      tick;
    end
    reset = 0;
    smp;
    chk("lit_sim_n_en", {31'b0, ram_enable}, 32'h1);
    chk("lit_sim_n_addr", ram_address, 32'h104);
    chk("lit_sim_n_rdy", {30'b0, fetch_ready, data_ready}, 32'h0);
    tick;
    smp;
    chk("lit_sim_n1_rdy", {30'b0, fetch_ready, data_ready}, 32'h1);
    chk("lit_sim_n1_dv", data_read_value, 32'h11112222);
    chk("lit_sim_n1_addr", ram_address, 32'h108);
    tick;
    data_request = 0;
    smp;
    chk("lit_sim_n2_rdy", {30'b0, fetch_ready, data_ready}, 32'h2);
    chk("lit_sim_n2_fv", fetch_value, 32'h22223333);
    tick;
    fetch_request = 0;
    smp;
    chk("lit_sim_n3_en", {31'b0, ram_enable}, 32'h0);
    chk("lit_sim_n3_dv", data_read_value, 32'h11112222);
    tick;
    fetch_request = 1;
    fetch_address = 32'h100;
    smp;
    chk("lit_sf_en", {31'b0, ram_enable}, 32'h1);
    chk("lit_sf_rdy0", {31'b0, fetch_ready}, 32'h0);
    tick;
    smp;
    chk("lit_sf_rdy", {31'b0, fetch_ready}, 32'h1);
    chk("lit_sf_fv", fetch_value, 32'h00500093);
    tick;
    fetch_request = 0;
    repeat (4) begin
      smp;
      chk("lit_sf_hold_rdy", {31'b0, fetch_ready}, 32'h0);
      chk("lit_sf_hold_fv", fetch_value, 32'h00500093);
      tick;
    end
    data_request = 1;
    data_address = 32'h200;
    data_write_sections = 3'b111;
    data_write_value = 32'hDEADBEEF;
    smp;
    chk("lit_sw_sec", {29'b0, ram_write_sections}, 32'h7);
    chk("lit_sw_wv", ram_write_value, 32'hDEADBEEF);
    tick;
    smp;
    chk("lit_sw_ack", {31'b0, data_ready}, 32'h1);
    chk("lit_sw_hold", data_read_value, 32'h11112222);
    tick;
    data_request = 0;
    fetch_request = 1;
    fetch_address = 32'h200;
    smp;
    tick;
    smp;
    chk("lit_sw_fetch_rdy", {31'b0, fetch_ready}, 32'h1);
    chk("lit_sw_fetch_fv", fetch_value, 32'hDEADBEEF);
    tick;
    fetch_request = 0;
    data_request = 1;
    data_write_sections = 3'b001;
    data_write_value = 32'hAAAAAA12;
    smp;
    chk("lit_sb_issue_hold", data_read_value, 32'h11112222);
    tick;
    smp;
    chk("lit_sb_ack", {31'b0, data_ready}, 32'h1);
    chk("lit_sb_hold", data_read_value, 32'h11112222);
    tick;
    data_write_sections = 3'b000;
    smp;
    chk("lit_lb_issue", {31'b0, ram_enable}, 32'h1);
    tick;
    smp;
    chk("lit_lb_rdy", {31'b0, data_ready}, 32'h1);
    chk("lit_lb_val", data_read_value, 32'hDEADBE12);
    tick;
    data_request = 0;
    tick;
    reset = 1;
    data_request = 1;
    data_address = 32'h300;
    data_write_sections = 3'b111;
    data_write_value = 32'hCAFEF00D;
    smp;
    chk("lit_rmid_sec", {29'b0, ram_write_sections}, 32'h0);
    chk("lit_rmid_en", {31'b0, ram_enable}, 32'h0);
    tick;
    reset = 0;
    data_request = 0;
    repeat (2) begin
      smp;
      chk("lit_rmid_nordy", {30'b0, fetch_ready, data_ready}, 32'h0);
      tick;
    end
    data_request = 1;
    data_write_sections = 3'b000;
    smp;
    tick;
    smp;
    chk("lit_rmid_rdy", {31'b0, data_ready}, 32'h1);
    chk("lit_rmid_old", data_read_value, 32'h0BADF00D);
    tick;
    data_request = 0;
    tick;
    fetch_request = 1;
    data_request = 1;
    new_fetch();
    new_data();
    for (int k = 0; k < 10; k++) begin
      smp;
      if (k > 0) begin
        chk("lit_cont_d", {31'b0, data_ready}, 32'(k % 2));
        chk("lit_cont_f", {31'b0, fetch_ready}, 32'(1 - k % 2));
      end
      tick;
      if (d_seen) new_data();
      if (f_seen) new_fetch();
    end
    data_request = 0;
    smp;
    chk("lit_cont_last", {31'b0, fetch_ready}, 32'h1);
    tick;
    fetch_request = 0;
    for (int c = 0; c < 3000; c++) begin
      tick;
      reset = $urandom_range(0, 199) == 0;
      if (fetch_request && f_seen) begin
        fetch_request = $urandom_range(0, 1) == 1;
        if (fetch_request) new_fetch();
      end else if (!fetch_request && $urandom_range(0, 2) == 0) begin
        fetch_request = 1;
        new_fetch();
      end
      if (data_request && d_seen) begin
        data_request = $urandom_range(0, 1) == 1;
        if (data_request) new_data();
      end else if (!data_request && $urandom_range(0, 2) == 0) begin
        data_request = 1;
        new_data();
      end
    end
    tick;
    reset = 0;
    fetch_request = 0;
    data_request = 0;
    repeat (4) tick;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
